// File: rtl/logic_unit_pkg.sv
// Shared definitions for logic_unit_pipe: op encoding and default sizing.
package logic_unit_pkg;

  // 3-bit operation select; every code is defined.
  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  localparam int unsigned LU_DEPTH = 4;
  localparam int unsigned LU_CNT_W = 16;

endpackage

// File: rtl/logic_unit_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit; full/empty come from comparing the
// next-state pointers so both flags are available straight from flops.
module logic_unit_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;

  assign w_push       = i_wr_en && !r_full;
  assign w_pop        = i_rd_en && !r_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);

  // Pointer and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_full   <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                  (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
    end
  end

  // Storage array; cleared on reset so the read port shows zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with a result FIFO and valid/ready handshakes.
// Optional macro LOGIC_UNIT_PARITY_EN adds y_par (XOR-reduction of y) stored
// alongside each result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = LU_DEPTH,
  parameter int unsigned CNT_W = LU_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic [CNT_W-1:0] done_cnt
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             y_par
`endif
);

`ifdef LOGIC_UNIT_PARITY_EN
  localparam int unsigned DW = WIDTH + 1;
`else
  localparam int unsigned DW = WIDTH;
`endif

  logic [WIDTH-1:0] w_result;
  logic [DW-1:0]    w_wr_data;
  logic [DW-1:0]    w_rd_data;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] r_done_cnt;

  // Operation decode on the incoming operands.
  always_comb begin
    w_result = '0;
    unique case (op_t'(op))
      OP_NOT:  w_result = ~a;
      OP_AND:  w_result = a & b;
      OP_OR:   w_result = a | b;
      OP_XOR:  w_result = a ^ b;
      OP_NAND: w_result = ~(a & b);
      OP_NOR:  w_result = ~(a | b);
      OP_XNOR: w_result = ~(a ^ b);
      OP_PASS: w_result = a;
    endcase
  end

`ifdef LOGIC_UNIT_PARITY_EN
  assign w_wr_data = {^w_result, w_result};
  assign y_par     = w_rd_data[WIDTH];
`else
  assign w_wr_data = w_result;
`endif

  logic_unit_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (in_valid),
    .i_wr_data (w_wr_data),
    .i_rd_en   (out_ready),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Completed output handshake counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_done_cnt <= r_done_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign y         = w_rd_data[WIDTH-1:0];
  assign y_zero    = out_valid && (y == '0);
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (default 8-bit, depth 4).
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  y;
  logic        y_zero;
  logic [15:0] done_cnt;
`ifdef LOGIC_UNIT_PARITY_EN
  logic        y_par;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  logic_unit_pipe #(
    .WIDTH (8),
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_zero    (y_zero),
    .done_cnt  (done_cnt)
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    .y_par     (y_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    sweep_exp = '{8'h33, 8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'hCC};

    // Reset state
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'h00);
    check("rst_y_zero", 32'(y_zero), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
`ifdef LOGIC_UNIT_PARITY_EN
    check("rst_y_par", 32'(y_par), 32'd0);
`endif
    rst_n = 1'b1;

    // Legacy NOT, one-cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 3'd0;
    a         = 8'hFF;
    step();
    check("not_ff_valid", 32'(out_valid), 32'd1);
    check("not_ff_y", 32'(y), 32'h00);
    check("not_ff_zero", 32'(y_zero), 32'd1);
    a = 8'h00;
    step();
    check("not_00_y", 32'(y), 32'hFF);
    check("not_00_zero", 32'(y_zero), 32'd0);
    in_valid = 1'b0;
    step();
    check("not_drain_valid", 32'(out_valid), 32'd0);
    check("not_done_cnt", 32'(done_cnt), 32'd2);

    // Sweep all ops with streaming handshake
    in_valid = 1'b1;
    a        = 8'hCC;
    b        = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      step();
      check($sformatf("sweep_y_op%0d", i), 32'(y), 32'(sweep_exp[i]));
      check($sformatf("sweep_zero_op%0d", i), 32'(y_zero), 32'd0);
      check($sformatf("sweep_in_ready_op%0d", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("sweep_done_cnt", 32'(done_cnt), 32'd10);

    // Backpressure: fill to full, fifth beat waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 3'd7;
    for (int k = 1; k <= 4; k++) begin
      a = 8'(k);
      step();
      check($sformatf("fill_in_ready_%0d", k), 32'(in_ready), (k == 4) ? 32'd0 : 32'd1);
    end
    a = 8'd5;
    step();
    check("full_hold_in_ready", 32'(in_ready), 32'd0);
    check("full_hold_y", 32'(y), 32'd1);
    out_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      check($sformatf("drain_valid_%0d", j), 32'(out_valid), 32'd1);
      check($sformatf("drain_y_%0d", j), 32'(y), 32'(j));
      step();
      if (j == 1) check("pop_frees_slot", 32'(in_ready), 32'd1);
      if (j == 2) in_valid = 1'b0;
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_done_cnt", 32'(done_cnt), 32'd15);

    // Sustained push/pop for 20 beats, covers pointer wrap
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 8'h40 + 8'(i);
      step();
      check($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'd1);
      check($sformatf("stream_y_%0d", i), 32'(y), 32'h40 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream_empty", 32'(out_valid), 32'd0);
    check("stream_done_cnt", 32'(done_cnt), 32'd35);

    // Zero flag and parity
    in_valid = 1'b1;
    op       = 3'd1;
    a        = 8'h0F;
    b        = 8'hF0;
    step();
    check("zero_y", 32'(y), 32'h00);
    check("zero_flag", 32'(y_zero), 32'd1);
`ifdef LOGIC_UNIT_PARITY_EN
    check("zero_par", 32'(y_par), 32'd0);
`endif
    a = 8'h07;
    b = 8'h03;
    step();
    check("and_y", 32'(y), 32'h03);
    check("and_zero", 32'(y_zero), 32'd0);
`ifdef LOGIC_UNIT_PARITY_EN
    check("and_par", 32'(y_par), 32'd0);
`endif
    op = 3'd3;
    a  = 8'h01;
    b  = 8'h00;
    step();
    check("xor_y", 32'(y), 32'h01);
`ifdef LOGIC_UNIT_PARITY_EN
    check("xor_par", 32'(y_par), 32'd1);
`endif
    in_valid = 1'b0;
    step();
    check("zero_done_cnt", 32'(done_cnt), 32'd38);

    // Reset with three entries queued
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 3'd7;
    for (int k = 0; k < 3; k++) begin
      a = 8'hA1 + 8'(k);
      step();
    end
    in_valid = 1'b0;
    check("preq_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_done_cnt", 32'(done_cnt), 32'd0);
    check("arst_y_zero", 32'(y_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 8'h5A;
    step();
    check("post_rst_y", 32'(y), 32'h5A);
    in_valid = 1'b0;
    step();
    check("post_rst_empty", 32'(out_valid), 32'd0);
    check("post_rst_done_cnt", 32'(done_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the fixed 8-bit combinational inverter.
- Computes one of eight bitwise operations on WIDTH-bit operands and buffers results in a DEPTH-entry output FIFO.
- Valid/ready handshakes on both sides.
- Sits between the datapath operand mux and downstream consumers; tolerates downstream backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (≥1).
- DEPTH, 4, result FIFO entries (power of 2, ≥2).
- CNT_W, 16, width of completed-transaction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat (registered)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored for unary ops)
- op  in  3  operation select
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- y_zero  out  1  y == 0, qualified by out_valid
- done_cnt  out  CNT_W  count of output handshakes

Behaviour:
- Clock and reset: one clock domain, clk; reset is asynchronous, active-low (rst_n), fully asynchronous assert, deassert sampled on clk.
- Op encoding:
  - 0 NOT a (legacy mode)
  - 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR
  - 7 PASS a
- Input handshake: beat accepted on a cycle with in_valid && in_ready. a, b and op are sampled together. Result is computed combinationally and written to the FIFO the same edge.
- in_ready: equals !full, driven from a register; no combinational path from out_ready.
- Output handshake: pop on out_valid && out_ready. y and y_zero are stable while out_valid=1 and out_ready=0.
- Latency: accept at edge N with FIFO empty → out_valid=1 after edge N; no same-cycle bypass.
- Throughput: 1 beat/cycle sustained when out_ready held high.
- Full: in_ready=0; a simultaneous pop frees a slot, so in_ready=1 the next cycle.
- Empty: out_valid=0; y holds the last popped value (don't-care for checking).
- Simultaneous push/pop with FIFO non-empty and non-full: occupancy unchanged, order preserved.
- Pointers: log2(DEPTH)+1 bits; wrap-around modulo DEPTH; full/empty from the MSB compare.
- done_cnt: +1 per output handshake, wraps 2^CNT_W−1 → 0.
- Reset values: in_ready=1, out_valid=0, y=0, y_zero=0 (y_zero is 0 while out_valid=0), done_cnt=0, pointers=0.
- Reset mid-operation: FIFO contents discarded, all state returns to reset values immediately.
- Illegal op: none exist; all 3-bit codes are defined.

Optional Feature:
- LOGIC_UNIT_PARITY_EN
- Defined:
  - adds output port y_par (1 bit) = XOR-reduction of y, stored alongside y in the FIFO.
  - y_par resets to 0.
- Undefined: port absent, FIFO width is WIDTH only.

Decomposition:
- Package logic_unit_pkg: op code constants (OP_NOT…OP_PASS), 3-bit op typedef, default DEPTH/CNT_W constants.
- Sub-module logic_unit_fifo: parametrised sync FIFO (data width, DEPTH) with registered full/empty. The parent contains the op decode, the counter and the zero flag.

Test Plan:
- Reset, then op=0, a=8'hFF, then a=8'h00, out_ready=1 → y=8'h00 then 8'hFF in order, each 1 cycle after accept; done_cnt=2.
- Sweep all ops with a=8'hCC, b=8'hAA → y = 33, 88, EE, 66, 77, 11, 99, CC; y_zero=0 throughout.
- out_ready=0, push 5 beats → 4 accepted, in_ready=0 after the 4th. Raise out_ready → 4 results in order, then the 5th accepted.
- Push and pop every cycle for 20 beats starting empty → no stall, in_ready stays 1, done_cnt=20; covers pointer wrap.
- Assert rst_n=0 with 3 entries queued → out_valid=0, in_ready=1, done_cnt=0 immediately; no stale data after release.
- With LOGIC_UNIT_PARITY_EN: op=1, a=8'h07, b=8'h03 → y=8'h03, y_par=0, y_zero=0; a=8'h0F, b=8'hF0 → y=0, y_zero=1, y_par=0.
